hazard_stall_ctrl: RTL and testbench

Pipeline hazard and multicycle-unit sequencer for the 5-stage 32-bit core. Sits beside operand forwarding. Handles two jobs:
- Detects load-use hazards between FD and DX, and issues the freeze/bubble/flush controls.
- Starts the multiplier/divider and holds the pipeline until that unit reports ready.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_pkg.sv | 45 ++++
 rtl/hazard_stall_ctrl_if.sv | 48 ++++
 rtl/hazard_src_decode.sv | 65 ++++++
 rtl/hazard_stall_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the hazard / multicycle sequencer and its decoders:
//   - instruction field bit positions (op, rd, rs, rt, aluop)
//   - opcode and aluop constants used by hazard detection
//   - multdiv sequencer state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

   // Instruction field positions
   localparam int OP_HI  = 31;
   localparam int OP_LO  = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;

   // Opcodes
   localparam logic [4:0] OP_R    = 5'd0;
   localparam logic [4:0] OP_BNE  = 5'd2;
   localparam logic [4:0] OP_JR   = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_BLT  = 5'd6;
   localparam logic [4:0] OP_SW   = 5'd7;
   localparam logic [4:0] OP_LW   = 5'd8;

   // R-type aluop values routed to the multdiv unit
   localparam logic [4:0] ALU_MUL = 5'd6;
   localparam logic [4:0] ALU_DIV = 5'd7;

   typedef logic [4:0] regIdxT;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      DONE
   } mdStateT;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundle between the pipeline / multdiv unit and the hazard sequencer.
//   fd_ir, dx_ir      instructions in the FD and DX latches
//   branch_taken      X-stage redirect this cycle
//   md_ready          multdiv result valid
//   perf_clear        synchronous clear of stall_cycles
//   stall_pc/fd/dx    hold PC, FD latch, DX latch
//   bubble_dx/xm      load a nop into DX / XM
//   flush             nop FD and DX (wrong path)
//   md_mult, md_div   one-cycle multdiv start pulses
//   md_sel            XM takes the multdiv result
//   md_exc            one-cycle multdiv timeout exception
//   stall_cycles      saturating count of PC-stall cycles
// Modports: master = pipeline side, slave = sequencer.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      fd_ir;
   logic [31:0]      dx_ir;
   logic             branch_taken;
   logic             md_ready;
   logic             perf_clear;
   logic             stall_pc;
   logic             stall_fd;
   logic             stall_dx;
   logic             bubble_dx;
   logic             bubble_xm;
   logic             flush;
   logic             md_mult;
   logic             md_div;
   logic             md_sel;
   logic             md_exc;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output fd_ir, dx_ir, branch_taken, md_ready, perf_clear,
      input  stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush,
             md_mult, md_div, md_sel, md_exc, stall_cycles
   );

   modport slave (
      input  fd_ir, dx_ir, branch_taken, md_ready, perf_clear,
      output stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush,
             md_mult, md_div, md_sel, md_exc, stall_cycles
   );
endinterface

// File: rtl/hazard_src_decode.sv
// ---------------------------------------------------------------------------
// hazard_src_decode
// Maps an instruction to the (up to two) architectural registers it reads.
// Shared by load-use detection and operand forwarding.
//   instr      in   32  instruction word
//   srcA/srcB  out   5  source register indices
//   srcAValid  out   1  srcA is really read
//   srcBValid  out   1  srcB is really read
// ---------------------------------------------------------------------------
module hazard_src_decode
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output regIdxT      srcA,
   output regIdxT      srcB,
   output logic        srcAValid,
   output logic        srcBValid
);

   logic [4:0] op;
   regIdxT     rd;
   regIdxT     rs;
   regIdxT     rt;
   logic       unusedBits;

   assign op = instr[OP_HI:OP_LO];
   assign rd = instr[RD_HI:RD_LO];
   assign rs = instr[RS_HI:RS_LO];
   assign rt = instr[RT_HI:RT_LO];

   // Immediate / function bits carry no register numbers.
   assign unusedBits = ^instr[11:0];

   // NOTE: every output gets a default before the case so that no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      srcA      = '0;
      srcB      = '0;
      srcAValid = 1'b0;
      srcBValid = 1'b0;
      case (op)
         OP_R: begin
            srcA = rs; srcAValid = 1'b1;
            srcB = rt; srcBValid = 1'b1;
         end
         OP_ADDI, OP_LW: begin
            srcA = rs; srcAValid = 1'b1;
         end
         OP_SW: begin
            // Store reads the base (rs) and the data register (rd).
            srcA = rs; srcAValid = 1'b1;
            srcB = rd; srcBValid = 1'b1;
         end
         OP_BNE, OP_BLT: begin
            srcA = rd; srcAValid = 1'b1;
            srcB = rs; srcBValid = 1'b1;
         end
         OP_JR: begin
            srcA = rd; srcAValid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Load-use hazard detection and multdiv sequencing for the 5-stage core,
// plus a saturating stall-cycle performance counter.
//   clock      in   rising-edge system clock
//   reset_n    in   asynchronous active-low reset
//   bus        slave side of hazard_stall_ctrl_if (see interface header)
// Parameters:
//   MD_TIMEOUT  max BUSY cycles before forced release with md_exc
//   CNT_W       width of stall_cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
)
(
   input  logic                clock,
   input  logic                reset_n,
   hazard_stall_ctrl_if.slave  bus
);

   localparam int            TO_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

   // ---------------- decode ----------------
   regIdxT     fdSrcA;
   regIdxT     fdSrcB;
   logic       fdSrcAValid;
   logic       fdSrcBValid;

   hazard_src_decode fdDecode (
      .instr     (bus.fd_ir),
      .srcA      (fdSrcA),
      .srcB      (fdSrcB),
      .srcAValid (fdSrcAValid),
      .srcBValid (fdSrcBValid)
   );

   logic [4:0] dxOp;
   regIdxT     dxRd;
   logic [4:0] dxAlu;
   logic       unusedDx;
   logic       dxIsMul;
   logic       dxIsDiv;
   logic       loadUse;

   assign dxOp  = bus.dx_ir[OP_HI:OP_LO];
   assign dxRd  = bus.dx_ir[RD_HI:RD_LO];
   assign dxAlu = bus.dx_ir[ALU_HI:ALU_LO];
   assign unusedDx = ^{bus.dx_ir[RS_HI:RT_LO], bus.dx_ir[11:7], bus.dx_ir[1:0]};

   assign dxIsMul = (dxOp == OP_R) && (dxAlu == ALU_MUL);
   assign dxIsDiv = (dxOp == OP_R) && (dxAlu == ALU_DIV);

   // A load into r0 never creates a real dependency.
   assign loadUse = (dxOp == OP_LW) && (dxRd != '0) &&
                    ((fdSrcAValid && (fdSrcA == dxRd)) ||
                     (fdSrcBValid && (fdSrcB == dxRd)));

   // ---------------- sequencer ----------------
   mdStateT         state;
   mdStateT         nextState;
   logic [TO_W-1:0] toCnt;
   logic            excFlag;
   logic            isDiv;
   logic            timedOut;

   logic            stallFront;
   logic            stallDx;
   logic            bubbleDx;
   logic            bubbleXm;
   logic            mdSel;

   assign timedOut = (toCnt == TO_LAST);

   always_comb begin
      nextState  = state;
      stallFront = 1'b0;
      stallDx    = 1'b0;
      bubbleDx   = 1'b0;
      bubbleXm   = 1'b0;
      mdSel      = 1'b0;
      case (state)
         IDLE: begin
            // A redirect squashes whatever is in DX, so neither the multdiv
            // start nor the load-use stall may act on it.
            if (!bus.branch_taken) begin
               if (dxIsMul || dxIsDiv) begin
                  stallFront = 1'b1;
                  stallDx    = 1'b1;
                  bubbleXm   = 1'b1;
                  nextState  = START;
               end else if (loadUse) begin
                  stallFront = 1'b1;
                  bubbleDx   = 1'b1;
               end
            end
         end
         START: begin
            stallFront = 1'b1;
            stallDx    = 1'b1;
            bubbleXm   = 1'b1;
            nextState  = BUSY;
         end
         BUSY: begin
            stallFront = 1'b1;
            stallDx    = 1'b1;
            bubbleXm   = 1'b1;
            if (bus.md_ready || timedOut) nextState = DONE;
         end
         DONE: begin
            // DX advances this cycle carrying the multdiv result into XM.
            mdSel     = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         toCnt   <= '0;
         excFlag <= 1'b0;
         isDiv   <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            IDLE:  if (nextState == START) isDiv <= dxIsDiv;
            START: toCnt <= '0;
            BUSY: begin
               toCnt <= toCnt + 1'b1;
               // A ready arriving on the last allowed cycle is a normal finish.
               if (!bus.md_ready && timedOut) excFlag <= 1'b1;
            end
            DONE:  excFlag <= 1'b0;
            default: ;
         endcase
      end
   end

   // ---------------- performance counter ----------------
   logic [CNT_W-1:0] stallCnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stallCnt <= '0;
      end else if (bus.perf_clear) begin
         stallCnt <= '0;
      end else if (stallFront && !(&stallCnt)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   // ---------------- outputs ----------------
   assign bus.stall_pc     = stallFront;
   assign bus.stall_fd     = stallFront;
   assign bus.stall_dx     = stallDx;
   assign bus.bubble_dx    = bubbleDx;
   assign bus.bubble_xm    = bubbleXm;
   assign bus.flush        = bus.branch_taken;
   assign bus.md_mult      = (state == START) && !isDiv;
   assign bus.md_div       = (state == START) && isDiv;
   assign bus.md_sel       = mdSel;
   assign bus.md_exc       = (state == DONE) && excFlag;
   assign bus.stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed bench for hazard_stall_ctrl: load-use cases, mul/div sequencing,
// timeout exception, branch override, mid-operation reset and the
// saturating stall counter with clear.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   logic clock;
   logic reset_n;

   hazard_stall_ctrl_if #(.CNT_W(16)) bus ();

   hazard_stall_ctrl #(
      .MD_TIMEOUT (64),
      .CNT_W      (16)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Control vector: {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm,
   //                  flush, md_mult, md_div, md_sel, md_exc}
   logic [9:0] ctl;
   assign ctl = {bus.stall_pc, bus.stall_fd, bus.stall_dx, bus.bubble_dx,
                 bus.bubble_xm, bus.flush, bus.md_mult, bus.md_div,
                 bus.md_sel, bus.md_exc};

   localparam logic [9:0] C_NONE = 10'b00_0_0_0_0_0_0_0_0;
   localparam logic [9:0] C_LU   = 10'b11_0_1_0_0_0_0_0_0;
   localparam logic [9:0] C_MDS  = 10'b11_1_0_1_0_0_0_0_0;
   localparam logic [9:0] C_FL   = 10'b00_0_0_0_1_0_0_0_0;
   localparam logic [9:0] C_MUL  = 10'b11_1_0_1_0_1_0_0_0;
   localparam logic [9:0] C_DIV  = 10'b11_1_0_1_0_0_1_0_0;
   localparam logic [9:0] C_SEL  = 10'b00_0_0_0_0_0_0_1_0;
   localparam logic [9:0] C_EXC  = 10'b00_0_0_0_0_0_0_1_1;

   int          nTotal = 0;
   int          nBad   = 0;
   logic [15:0] expCnt = '0;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'd0};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      nTotal++;
      if (got !== want) begin
         nBad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check the combinational
   // controls and the counter, then advance the counter model for the edge.
   task automatic step(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                       input logic br, input logic rdy, input logic clr,
                       input logic [9:0] want);
      @(negedge clock);
      bus.fd_ir        = fd;
      bus.dx_ir        = dx;
      bus.branch_taken = br;
      bus.md_ready     = rdy;
      bus.perf_clear   = clr;
      #1;
      check(tag, 32'(ctl), 32'(want));
      check({tag, "_cnt"}, 32'(bus.stall_cycles), 32'(expCnt));
      if (clr)                            expCnt = '0;
      else if (want[9] && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
   endtask

   logic [31:0] nop;
   logic [31:0] lwR5;
   logic [31:0] lwR0;
   logic [31:0] addR5;
   logic [31:0] mulI;
   logic [31:0] divI;

   initial begin
      nop   = 32'd0;
      lwR5  = mk(OP_LW, 5'd5, 5'd1, 5'd0, 5'd0);
      lwR0  = mk(OP_LW, 5'd0, 5'd1, 5'd0, 5'd0);
      addR5 = mk(OP_R, 5'd1, 5'd5, 5'd2, 5'd0);
      mulI  = mk(OP_R, 5'd3, 5'd1, 5'd2, ALU_MUL);
      divI  = mk(OP_R, 5'd3, 5'd1, 5'd2, ALU_DIV);

      reset_n          = 1'b0;
      bus.fd_ir        = nop;
      bus.dx_ir        = nop;
      bus.branch_taken = 1'b0;
      bus.md_ready     = 1'b0;
      bus.perf_clear   = 1'b0;
      #1;
      check("rst_ctl", 32'(ctl), 32'(C_NONE));
      check("rst_cnt", 32'(bus.stall_cycles), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Load-use detection
      step("lu_hit",     addR5, lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("lu_gone",    addR5, nop,  1'b0, 1'b0, 1'b0, C_NONE);
      step("lu_other",   mk(OP_R, 5'd1, 5'd6, 5'd2, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_NONE);
      step("lu_r0",      mk(OP_R, 5'd1, 5'd0, 5'd0, 5'd0), lwR0, 1'b0, 1'b0, 1'b0, C_NONE);
      step("lu_rt",      mk(OP_R, 5'd1, 5'd2, 5'd5, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("lu_sw_rd",   mk(OP_SW, 5'd5, 5'd1, 5'd0, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("lu_jr",      mk(OP_JR, 5'd5, 5'd0, 5'd0, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("lu_addi_rt", mk(OP_ADDI, 5'd5, 5'd6, 5'd5, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_NONE);
      step("lu_blt_rs",  mk(OP_BLT, 5'd1, 5'd5, 5'd0, 5'd0), lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("lu_flush",   addR5, lwR5, 1'b1, 1'b0, 1'b0, C_FL);
      step("lu_idle",    nop,   nop,  1'b0, 1'b0, 1'b0, C_NONE);

      // Multiply, ready in the third BUSY cycle (ready in START is ignored)
      step("mul_idle",   nop, mulI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("mul_start",  nop, mulI, 1'b0, 1'b1, 1'b0, C_MUL);
      step("mul_busy1",  nop, mulI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("mul_busy2",  nop, mulI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("mul_busy3",  nop, mulI, 1'b0, 1'b1, 1'b0, C_MDS);
      step("mul_done",   nop, mulI, 1'b0, 1'b1, 1'b0, C_SEL);
      step("mul_after",  nop, nop,  1'b0, 1'b1, 1'b0, C_NONE);
      step("mul_after2", nop, nop,  1'b0, 1'b0, 1'b0, C_NONE);

      // Divide that never completes: 64 BUSY cycles then timeout exception
      step("div_idle",  nop, divI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("div_start", nop, divI, 1'b0, 1'b0, 1'b0, C_DIV);
      for (int i = 0; i < 64; i++)
         step($sformatf("div_busy%0d", i), nop, divI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("div_done",  nop, divI, 1'b0, 1'b0, 1'b0, C_EXC);
      step("div_after", nop, nop,  1'b0, 1'b0, 1'b0, C_NONE);

      // Branch overrides a mul/div start in IDLE
      step("br_mul",    nop, mulI, 1'b1, 1'b0, 1'b0, C_FL);
      step("br_after",  nop, nop,  1'b0, 1'b0, 1'b0, C_NONE);

      // Reset during BUSY
      step("rb_idle",   nop, mulI, 1'b0, 1'b0, 1'b0, C_MDS);
      step("rb_start",  nop, mulI, 1'b0, 1'b0, 1'b0, C_MUL);
      step("rb_busy",   nop, mulI, 1'b0, 1'b0, 1'b0, C_MDS);
      @(negedge clock);
      reset_n   = 1'b0;
      bus.dx_ir = nop;
      #1;
      check("rb_rst_ctl", 32'(ctl), 32'(C_NONE));
      check("rb_rst_cnt", 32'(bus.stall_cycles), 32'd0);
      expCnt = '0;
      @(negedge clock);
      reset_n = 1'b1;
      step("rb_after",  nop, nop, 1'b0, 1'b0, 1'b0, C_NONE);
      step("rb_after2", nop, nop, 1'b0, 1'b0, 1'b0, C_NONE);

      // Saturation and clear priority
      @(negedge clock);
      bus.fd_ir = addR5;
      bus.dx_ir = lwR5;
      repeat (65540) @(negedge clock);
      #1;
      check("sat_cnt", 32'(bus.stall_cycles), 32'h0000_FFFF);
      expCnt = 16'hFFFF;
      step("clr_sat",   addR5, lwR5, 1'b0, 1'b0, 1'b1, C_LU);
      step("clr_after", addR5, lwR5, 1'b0, 1'b0, 1'b0, C_LU);
      step("clr_final", nop,   nop,  1'b0, 1'b0, 1'b0, C_NONE);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
